// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_ctrl divided-clock generator: state
// encoding, default width and the minimum legal half-period.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_HALF  = 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

endpackage

// File: rtl/clk_div_counter.sv
// Half-period counter: counts 0..half-1 while enabled and flags the
// terminal count; held at zero while clr is asserted.
module clk_div_counter #(
  parameter int DIV_W = 8
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] half,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = (cnt == half - DIV_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divided-clock / tick generator with glitch-free start/stop
// and boundary-aligned divide updates. Optional tick counter: CLK_DIV_TICK_COUNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_half
`ifdef CLK_DIV_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  state_t           state, state_nxt;
  logic             clk_nxt, tick_nxt;
  logic             tc, pend, xfer, apply;
  logic [DIV_W-1:0] pend_val, sat_val;

  clk_div_counter #(.DIV_W(DIV_W)) u_counter (
    .in_clk (in_clk),
    .rst    (rst),
    .en     (state != IDLE),
    .clr    (state == IDLE),
    .half   (cur_half),
    .tc     (tc)
  );

  assign div_ready = ~pend;
  assign xfer      = div_valid && div_ready;
  assign sat_val   = (div_val == '0) ? DIV_W'(MIN_HALF) : div_val;

  // NOTE: every output of this always_comb gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    clk_nxt   = clk_out;
    tick_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        if (tc) begin
          clk_nxt  = ~clk_out;
          tick_nxt = ~clk_out;
        end
        if (stop) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (start && !stop) begin
          state_nxt = RUN;
          if (tc) begin
            clk_nxt  = ~clk_out;
            tick_nxt = ~clk_out;
          end
        end else if (tc) begin
          // Finish the current phase low; never start a new high phase.
          clk_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending divide lands on a falling toggle or on the drop back to IDLE.
  assign apply = pend && ((clk_out && !clk_nxt) ||
                          (state != IDLE && state_nxt == IDLE));

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      running  <= 1'b0;
      cur_half <= DIV_W'(DEFAULT_HALF);
      pend_val <= DIV_W'(DEFAULT_HALF);
      pend     <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
      running <= (state_nxt != IDLE);
      if (apply) begin
        cur_half <= pend_val;
        pend     <= 1'b0;
      end else if (xfer) begin
        if (state == IDLE) begin
          cur_half <= sat_val;
        end else begin
          pend_val <= sat_val;
          pend     <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_DIV_TICK_COUNT_EN
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      tick_count <= '0;
    end else if (state == IDLE && state_nxt == RUN) begin
      tick_count <= '0;
    end else if (tick_nxt) begin
      tick_count <= tick_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-enable/divided-clock generator that sits directly downstream of the divide-by-two stage and runs on that stage's output clock (in_clk).
- Produces a software-programmable divided square wave clk_out and a one-cycle tick strobe aligned to each clk_out rising edge.
- Supports start/stop control without runt pulses.
- Takes new divide values through a valid/ready handshake; a new value takes effect only on a period boundary.

Parameters:
DIV_W, 8, width of half-period value.
DEFAULT_HALF, 1, half-period (in in_clk cycles) after reset; 1 reproduces divide-by-two.

Ports:
in_clk  input  1  sole clock (divided clock from upstream stage).
rst  input  1  asynchronous, active-low reset.
start  input  1  level, sampled each cycle; begin/resume generation.
stop  input  1  level, sampled each cycle; request glitch-free stop.
div_val  input  DIV_W  requested half-period.
div_valid  input  1  div_val valid.
div_ready  output  1  block can accept div_val.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle strobe on each clk_out rising edge.
running  output  1  state != IDLE.
cur_half  output  DIV_W  half-period currently in use.

Behaviour:
- Reset (rst==0, asynchronous):
  - State = IDLE; clk_out=0, tick=0, running=0, cnt=0.
  - cur_half=DEFAULT_HALF, pend=0, div_ready=1.
- States are IDLE, RUN and STOPPING. All outputs are registered.
- Half-period counter cnt (DIV_W bits):
  - In RUN or STOPPING, cnt increments each cycle.
  - Terminal count (TC) is cnt==cur_half-1. At TC, cnt wraps to 0.
  - In IDLE, cnt is held at 0.
- IDLE:
  - start=1 and stop=0: next cycle state=RUN, cnt=0, clk_out=0.
  - start and stop both 1: stop dominates, so the block stays IDLE.
- RUN:
  - At TC, clk_out toggles.
  - On a 0->1 toggle, tick=1 for that same cycle only (tick and clk_out rise together).
  - The first rising edge occurs cur_half cycles after entering RUN.
  - stop=1: next cycle state=STOPPING, counting continues unchanged.
  - start is ignored in RUN.
- STOPPING:
  - At TC, if clk_out=1: clk_out goes to 0 and state goes to IDLE.
  - At TC, if clk_out=0: clk_out stays 0 (no rising edge, no tick) and state goes to IDLE.
  - running drops in the same cycle state becomes IDLE.
  - start=1 and stop=0 while in STOPPING: return to RUN with no disturbance to cnt or clk_out.
- Divide-value handshake:
  - div_ready = ~pend. A transfer occurs when div_valid && div_ready.
  - div_val=0 is saturated to 1.
  - In IDLE, the accepted value loads cur_half on the next edge and pend stays 0.
  - In RUN or STOPPING, the accepted value goes to pend_val and pend=1.
  - pend_val is applied to cur_half at the next 1->0 clk_out toggle, or on the cycle of entry to IDLE, whichever comes first. pend clears at the same moment.
  - Only one pending value is held, so div_ready stays low until it is applied.
- Boundary cases:
  - cur_half=1: clk_out toggles every cycle.
  - cur_half=2^DIV_W-1: maximum half-period.
  - cnt never exceeds cur_half-1. cur_half only changes at a period boundary, so no truncated phase can occur.
- Reset asserted mid-operation forces all registers to their reset values immediately; clk_out may be cut short, which is acceptable on reset only.

Optional Feature:
Macro CLK_DIV_TICK_COUNT_EN.
- Defined:
  - Adds output tick_count (16 bits).
  - Increments on every tick and wraps from 0xFFFF to 0.
  - Cleared by reset and on each IDLE->RUN transition.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg holds:
  - State enum (IDLE, RUN, STOPPING).
  - DIV_W default.
  - Saturation helper constant (minimum half = 1).
- Sub-module clk_div_counter holds cnt with enable, clear and half inputs, and produces the TC output. It is reused for the half-period counting.
- The FSM, handshake and clk_out register stay in the top module.

Test Plan:
1. Reset release, DEFAULT_HALF=1, start pulse -> RUN next cycle; clk_out toggles every cycle; tick high every 2nd cycle; cur_half=1.
2. In IDLE, div_val=3 with div_valid, then start -> clk_out 3 cycles low, 3 high, repeating; tick period 6; first tick 3 cycles after RUN entry.
3. Running with half=2, div_val=5 offered mid high phase -> accepted, div_ready=0 until the next falling toggle; following phases are 5 cycles; div_ready returns to 1 on that same edge.
4. Half=4, stop asserted in cycle 1 of the high phase -> clk_out high for 4 cycles total, falls, running=0 that cycle, no further tick. Repeat with stop in the low phase -> clk_out stays 0 and IDLE is entered at TC with no tick.
5. div_val=0 accepted in IDLE -> cur_half=1. start and stop asserted together in IDLE -> stays IDLE, running=0.
6. rst driven low asynchronously mid-RUN with clk_out=1 -> clk_out=0, running=0, cur_half=DEFAULT_HALF without waiting for an in_clk edge. With CLK_DIV_TICK_COUNT_EN defined, tick_count=0.
